// File: rtl/wormhole_out_alloc_pkg.sv
// Shared definitions for the wormhole output allocator and its round-robin picker.
package wormhole_out_alloc_pkg;

    // Allocator FSM: free, or bound to one input for the duration of a packet
    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } alloc_state_e;

    localparam int unsigned DEF_IN_N    = 5;
    localparam int unsigned DEF_CREDITS = 4;

endpackage

// File: rtl/wormhole_out_alloc_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_pick #(
    parameter int unsigned N = 5
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic                 any,
    output logic [$clog2(N)-1:0] idx,
    output logic [N-1:0]         onehot
);
    localparam int unsigned W = $clog2(N);

    logic [2*N-1:0] dbl;
    logic           found;

    // Duplicated request vector: positions below ptr in the lower copy are masked,
    // so a plain low-to-high priority search yields the wrapped round-robin winner.
    always_comb begin
        dbl   = {req, req};
        found = 1'b0;
        idx   = '0;
        for (int unsigned i = 0; i < 2 * N; i++) begin
            if (!found && dbl[i] && (i >= 32'(ptr))) begin
                found = 1'b1;
                idx   = (i >= N) ? W'(i - N) : W'(i);
            end
        end
        any    = |req;
        onehot = any ? (N'(1) << idx) : '0;
    end

endmodule

// File: rtl/wormhole_out_alloc.sv
// Output-port allocator: round-robin grant held for a whole packet, credit-gated transfers.
module wormhole_out_alloc
    import wormhole_out_alloc_pkg::*;
#(
    parameter int unsigned IN_N    = DEF_IN_N,
    parameter int unsigned CREDITS = DEF_CREDITS
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic [IN_N-1:0]              req_i,
    input  logic [IN_N-1:0]              tail_i,
    input  logic                         credit_i,
    output logic [IN_N-1:0]              grant_o,
    output logic [$clog2(IN_N)-1:0]      grant_idx_o,
    output logic                         locked_o,
    output logic                         xfer_o,
    output logic [$clog2(CREDITS+1)-1:0] credit_cnt_o,
    output logic                         err_o
);
    localparam int unsigned IW = $clog2(IN_N);
    localparam int unsigned CW = $clog2(CREDITS + 1);

    alloc_state_e    state_q, state_d;
    logic [IW-1:0]   owner_q, ptr_q;
    logic [IN_N-1:0] owner_oh_q;
    logic [CW-1:0]   cred_q;
    logic            err_q;

    logic            pick_any;
    logic [IW-1:0]   pick_idx;
    logic [IN_N-1:0] pick_oh;
    logic            owner_req, owner_tail, xfer, release_pkt;

    rr_pick #(.N(IN_N)) u_pick (
        .req    (req_i),
        .ptr    (ptr_q),
        .any    (pick_any),
        .idx    (pick_idx),
        .onehot (pick_oh)
    );

    // Next state and transfer decision; tail only counts when the owner's request is up
    always_comb begin
        state_d     = state_q;
        owner_req   = |(req_i & owner_oh_q);
        owner_tail  = |(req_i & tail_i & owner_oh_q);
        xfer        = 1'b0;
        release_pkt = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pick_any) state_d = ST_LOCKED;
            end
            ST_LOCKED: begin
                xfer        = owner_req && (cred_q != '0);
                release_pkt = xfer && owner_tail;
                if (release_pkt) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM, owner capture on grant, pointer advance only on tail release
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            owner_q    <= '0;
            owner_oh_q <= '0;
            ptr_q      <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_IDLE && pick_any) begin
                owner_q    <= pick_idx;
                owner_oh_q <= pick_oh;
            end
            if (release_pkt)
                ptr_q <= (owner_q == IW'(IN_N - 1)) ? '0 : owner_q + IW'(1);
        end
    end

    // Saturating credit counter with sticky overflow flag
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cred_q <= CW'(CREDITS);
            err_q  <= 1'b0;
        end else begin
            if (xfer && !credit_i) begin
                cred_q <= cred_q - CW'(1);
            end else if (!xfer && credit_i) begin
                if (cred_q == CW'(CREDITS)) err_q  <= 1'b1;
                else                        cred_q <= cred_q + CW'(1);
            end
        end
    end

    // Output decode: owner outputs are forced to zero while unlocked
    always_comb begin
        locked_o     = (state_q == ST_LOCKED);
        grant_o      = locked_o ? owner_oh_q : '0;
        grant_idx_o  = locked_o ? owner_q : '0;
        xfer_o       = xfer;
        credit_cnt_o = cred_q;
        err_o        = err_q;
    end

endmodule

// File: tb/tb_wormhole_out_alloc.sv
// Self-checking bench: behavioural allocator model checked every cycle, plus directed literal checks.
module tb_wormhole_out_alloc;
    localparam int IN_N    = 5;
    localparam int CREDITS = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] req = '0, tail = '0;
    logic       credit = 1'b0;
    logic [4:0] grant;
    logic [2:0] gidx;
    logic       locked, xfer, err;
    logic [2:0] ccnt;

    int n_cmp = 0;
    int n_bad = 0;

    wormhole_out_alloc #(.IN_N(IN_N), .CREDITS(CREDITS)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .req_i        (req),
        .tail_i       (tail),
        .credit_i     (credit),
        .grant_o      (grant),
        .grant_idx_o  (gidx),
        .locked_o     (locked),
        .xfer_o       (xfer),
        .credit_cnt_o (ccnt),
        .err_o        (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: lock flag, owner, rotating start point, credit count, error flag
    int  m_locked = 0, m_owner = 0, m_ptr = 0, m_cred = CREDITS, m_err = 0;

    always @(negedge clk) begin
        int e_xfer, w;
        if (!rst_n) begin
            m_locked = 0; m_owner = 0; m_ptr = 0; m_cred = CREDITS; m_err = 0;
            chk("rst_grant", grant, 0);
            chk("rst_locked", locked, 0);
            chk("rst_xfer", xfer, 0);
            chk("rst_idx", gidx, 0);
            chk("rst_cnt", ccnt, CREDITS);
            chk("rst_err", err, 0);
        end else begin
            e_xfer = (m_locked && req[m_owner] && m_cred > 0) ? 1 : 0;
            chk("m_locked", locked, m_locked);
            chk("m_grant", grant, m_locked ? (1 << m_owner) : 0);
            chk("m_idx", gidx, m_locked ? m_owner : 0);
            chk("m_xfer", xfer, e_xfer);
            chk("m_cnt", ccnt, m_cred);
            chk("m_err", err, m_err);
            if (!m_locked) begin
                w = -1;
                for (int k = 0; k < IN_N; k++)
                    if (w < 0 && req[(m_ptr + k) % IN_N]) w = (m_ptr + k) % IN_N;
                if (w >= 0) begin m_owner = w; m_locked = 1; end
            end else if (e_xfer && tail[m_owner]) begin
                m_locked = 0;
                m_ptr = (m_owner + 1) % IN_N;
            end
            if (e_xfer && !credit) m_cred--;
            else if (!e_xfer && credit) begin
                if (m_cred == CREDITS) m_err = 1;
                else m_cred++;
            end
        end
    end

    // Apply one cycle of inputs just after the edge; literal checks follow at +3
    task automatic cyc(input logic [4:0] r, input logic [4:0] t, input logic c);
        @(posedge clk); #1;
        req = r; tail = t; credit = c;
        #2;
    endtask

    // Reset asserted between edges; outputs must clear before any clock edge
    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("async_grant", grant, 0);
        chk("async_locked", locked, 0);
        chk("async_cnt", ccnt, 4);
        chk("async_err", err, 0);
        req = '0; tail = '0; credit = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int seq [6];
        seq = '{0, 1, 2, 3, 4, 0};

        #12 rst_n = 1'b1;
        #1;
        chk("t1_grant", grant, 0);
        chk("t1_locked", locked, 0);
        chk("t1_cnt", ccnt, 4);
        chk("t1_err", err, 0);

        // Rotation with single-flit packets, one IDLE bubble between grants
        for (int i = 0; i < 12; i++) begin
            cyc(5'b11111, 5'b11111, 1'b1);
            if (i % 2 == 1) begin
                chk("t2_locked", locked, 1);
                chk("t2_owner", gidx, seq[i / 2]);
                chk("t2_xfer", xfer, 1);
            end else begin
                chk("t2_bubble", locked, 0);
            end
        end

        // Wormhole lock: 3-flit packet from input 2 while input 0 keeps requesting
        do_reset();
        cyc(5'b00100, 5'b00000, 1'b0); chk("t3_idle", locked, 0);
        cyc(5'b00101, 5'b00000, 1'b0); chk("t3_g1", grant, 5'b00100); chk("t3_x1", xfer, 1);
        cyc(5'b00101, 5'b00000, 1'b0); chk("t3_g2", grant, 5'b00100); chk("t3_x2", xfer, 1);
        cyc(5'b00101, 5'b00100, 1'b0); chk("t3_g3", grant, 5'b00100); chk("t3_x3", xfer, 1);
        cyc(5'b00001, 5'b00000, 1'b0); chk("t3_bubble", grant, 0);
        cyc(5'b00001, 5'b00000, 1'b0); chk("t3_next", grant, 5'b00001); chk("t3_cnt", ccnt, 1);

        // Credit stall: four transfers, then stall, one credit gives exactly one more
        do_reset();
        cyc(5'b00010, 5'b00000, 1'b0); chk("t4_idle", locked, 0);
        for (int i = 0; i < 4; i++) begin
            cyc(5'b00010, 5'b00000, 1'b0);
            chk("t4_xfer", xfer, 1);
            chk("t4_cnt", ccnt, 4 - i);
        end
        cyc(5'b00010, 5'b00000, 1'b0); chk("t4_stall", xfer, 0); chk("t4_zero", ccnt, 0);
        cyc(5'b00010, 5'b00000, 1'b1); chk("t4_stall2", xfer, 0); chk("t4_locked", locked, 1);
        cyc(5'b00010, 5'b00000, 1'b0); chk("t4_one", xfer, 1); chk("t4_cnt1", ccnt, 1);
        cyc(5'b00010, 5'b00000, 1'b0); chk("t4_after", xfer, 0); chk("t4_cnt0", ccnt, 0);

        // Simultaneous consume and return leaves the count unchanged
        cyc(5'b00010, 5'b00000, 1'b1); chk("t5_ret", xfer, 0);
        cyc(5'b00010, 5'b00000, 1'b1); chk("t5_both", xfer, 1); chk("t5_c1", ccnt, 1);
        cyc(5'b00010, 5'b00000, 1'b0); chk("t5_same", ccnt, 1); chk("t5_x", xfer, 1);
        do_reset();
        cyc(5'b00000, 5'b00000, 1'b1); chk("t5_full", ccnt, 4); chk("t5_err0", err, 0);
        cyc(5'b00000, 5'b00000, 1'b0); chk("t5_sat", ccnt, 4); chk("t5_err1", err, 1);
        for (int i = 0; i < 3; i++) begin
            cyc(5'b00000, 5'b00000, 1'b0); chk("t5_sticky", err, 1);
        end

        // Owner bubble: owner drops request while input 3 waits
        do_reset();
        cyc(5'b00001, 5'b00000, 1'b0); chk("t6_idle", locked, 0);
        cyc(5'b00001, 5'b00000, 1'b0); chk("t6_g", grant, 5'b00001); chk("t6_x", xfer, 1);
        for (int i = 0; i < 2; i++) begin
            cyc(5'b01000, 5'b00000, 1'b0);
            chk("t6_hold", grant, 5'b00001);
            chk("t6_nox", xfer, 0);
        end
        cyc(5'b01001, 5'b00001, 1'b0); chk("t6_tail", xfer, 1); chk("t6_g2", grant, 5'b00001);
        cyc(5'b01000, 5'b00000, 1'b0); chk("t6_bubble", locked, 0);
        cyc(5'b01000, 5'b00000, 1'b0); chk("t6_next", grant, 5'b01000);

        // Random traffic against the model, with occasional resets
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            req    = 5'($urandom);
            tail   = ($urandom_range(0, 2) == 0) ? 5'($urandom) : 5'b00000;
            credit = ($urandom_range(0, 2) == 0);
            if (!rst_n) rst_n = 1'b1;
            else if ($urandom_range(0, 299) == 0) rst_n = 1'b0;
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        req = '0; tail = '0; credit = 1'b0;
        @(negedge clk); #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
